// File: rtl/pdm_capture.sv
// pdm_capture: counts ones in a 1-bit pulse-density stream over each
// sample_clock period and emits one unsigned PCM word per valid window.
//
// Output handshake: pcm_valid is a one-cycle strobe with no ready/backpressure.
// pcm is stable from the strobe cycle until the next strobe or reset. err is an
// independent one-cycle strobe. locked is a level that is high while in RUN.
module pdm_capture #(
  parameter int BITDEPTH        = 14,
  parameter int SAMPLECLOCK_DIV = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clock,
  input  logic                din,
  output logic [BITDEPTH-1:0] pcm,
  output logic                pcm_valid,
  output logic                locked,
  output logic                err
);

  localparam int CW    = SAMPLECLOCK_DIV + 1;
  localparam int SHIFT = BITDEPTH - SAMPLECLOCK_DIV;

  // N, N-1, 2N-1 (saturation value) and 2N-2 (last cycle before saturation)
  localparam logic [CW-1:0] N_VAL  = CW'(1) << SAMPLECLOCK_DIV;
  localparam logic [CW-1:0] N_M1   = N_VAL - CW'(1);
  localparam logic [CW-1:0] SAT    = {CW{1'b1}};
  localparam logic [CW-1:0] TO_PRE = SAT - CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [1:0]          rst_sync_q;
  logic                rst_ni;
  logic [1:0]          din_sync_q;
  logic                din_s;
  logic                sc_d_q;
  logic                rise;
  logic [CW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       total;
  logic [BITDEPTH-1:0] scaled;
  state_t              state_q, state_d;
  logic [BITDEPTH-1:0] pcm_q, pcm_d;
  logic                pcm_valid_q, pcm_valid_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;

  // Reset synchroniser: asserts immediately, releases two clk edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_ni = rst_sync_q[1];
  assign din_s  = din_sync_q[1];

  // Edge detect, window total, scaling, counters and FSM next-state
  always_comb begin
    rise   = sample_clock & ~sc_d_q;
    total  = acc_q + CW'(din_s);
    // A full window of ones does not fit after the shift, so clamp to full scale
    if (total == N_VAL) scaled = {BITDEPTH{1'b1}};
    else                scaled = BITDEPTH'(total) << SHIFT;

    // The partial window before arming is discarded, so acc stays at 0 in IDLE
    acc_d = (rise || state_q == IDLE) ? '0 : total;

    if (rise)             cnt_d = '0;
    else if (cnt_q == SAT) cnt_d = cnt_q;
    else                  cnt_d = cnt_q + CW'(1);

    state_d     = state_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = RUN;
      end
      RUN: begin
        if (rise) begin
          // A rise always wins over a simultaneous timeout: a single period error
          if (cnt_q == N_M1) begin
            pcm_d       = scaled;
            pcm_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == TO_PRE) begin
          // cnt saturates this cycle without an edge: the sample clock is lost
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == RUN);
  end

  // All datapath and FSM registers
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      din_sync_q  <= 2'b00;
      sc_d_q      <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      din_sync_q  <= {din_sync_q[0], din};
      sc_d_q      <= sample_clock;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pdm_capture.sv
// Testbench for pdm_capture: directed sample_clock periods and din patterns,
// expected PCM words queued at stimulus time and checked by a monitor.
module tb_pdm_capture;

  localparam int BD = 14;
  localparam int SD = 8;

  // din pattern modes
  localparam int M_ZERO = 0;
  localparam int M_ONE  = 1;
  localparam int M_TOG  = 2;
  localparam int M_Q4   = 3;
  localparam int M_DAC  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_clock;
  logic          din;
  logic [BD-1:0] pcm;
  logic          pcm_valid;
  logic          locked;
  logic          err;

  int checks   = 0;
  int errors   = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  logic [14:0] dac_acc;

  logic [BD-1:0] exp_q[$];
  int            tol_q[$];

  // Clock and DUT
  always #5 clk = ~clk;

  pdm_capture #(.BITDEPTH(BD), .SAMPLECLOCK_DIV(SD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_clock (sample_clock),
    .din          (din),
    .pcm          (pcm),
    .pcm_valid    (pcm_valid),
    .locked       (locked),
    .err          (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int expv, input int tol);
    exp_q.push_back(BD'(expv));
    tol_q.push_back(tol);
  endtask

  // One sample_clock period of len cycles, rising edge on the last cycle.
  // din leads the window by the 2-flop synchroniser, so the last two cycles
  // already carry the next window's pattern.
  task automatic drive_period(input int len, input int m_now, input int m_next);
    for (int i = 0; i < len; i++) begin
      int m;
      m = (i < len - 2) ? m_now : m_next;
      @(negedge clk);
      sample_clock = (i == len - 1);
      case (m)
        M_ZERO:  din = 1'b0;
        M_ONE:   din = 1'b1;
        M_TOG:   din = (cyc % 2 == 1);
        M_Q4:    din = (cyc % 4 == 0);
        default: begin
          // first-order sigma-delta DAC with constant input 8192
          dac_acc = {1'b0, dac_acc[13:0]} + 15'd8192;
          din     = dac_acc[14];
        end
      endcase
      cyc++;
    end
  endtask

  // Monitor: counts err strobes and checks every pcm_valid against the queue
  always @(negedge clk) begin
    int e, t, d;
    if (err === 1'b1) err_cnt++;
    if (pcm_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: pcm=%0d with no expected sample", pcm);
      end else begin
        e = int'(exp_q.pop_front());
        t = tol_q.pop_front();
        d = int'(pcm) - e;
        if (d < 0) d = -d;
        if (d > t) begin
          errors++;
          $display("FAIL pcm_sample: got %0d expected %0d (tol %0d)", pcm, e, t);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    rst_n        = 1'b0;
    sample_clock = 1'b0;
    din          = 1'b0;
    dac_acc      = '0;

    // Reset with random inputs
    repeat (20) begin
      @(negedge clk);
      din          = 1'($urandom_range(0, 1));
      sample_clock = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    check("reset_pcm", 32'(pcm), 0);
    check("reset_pcm_valid", 32'(pcm_valid), 0);
    check("reset_locked", 32'(locked), 0);
    check("reset_err", 32'(err), 0);

    @(negedge clk);
    sample_clock = 1'b0;
    din          = 1'b0;
    rst_n        = 1'b1;
    repeat (4) @(negedge clk);

    // Arm, then two zero windows
    drive_period(10, M_ZERO, M_ZERO);
    @(posedge clk); #1;
    check("locked_after_arm", 32'(locked), 1);
    check("no_valid_on_arm", 32'(pcm_valid), 0);
    push(0, 0);     drive_period(256, M_ZERO, M_ZERO);
    push(0, 0);     drive_period(256, M_ZERO, M_ONE);

    // Full scale, half scale, quarter scale
    push(16383, 0); drive_period(256, M_ONE, M_ONE);
    push(16383, 0); drive_period(256, M_ONE, M_TOG);
    check("no_err_full_scale", 32'(err_cnt), 0);
    push(8192, 0);  drive_period(256, M_TOG, M_Q4);
    push(4096, 0);  drive_period(256, M_Q4, M_TOG);
    push(8192, 0);  drive_period(256, M_TOG, M_TOG);

    // Short period: err, no valid, pcm holds
    drive_period(200, M_TOG, M_Q4);
    @(posedge clk); #1;
    check("err_short_period", 32'(err), 1);
    check("no_valid_short", 32'(pcm_valid), 0);
    check("pcm_hold_short", 32'(pcm), 8192);
    check("locked_after_short", 32'(locked), 1);
    push(4096, 0);  drive_period(256, M_Q4, M_ZERO);
    check("err_count_short", 32'(err_cnt), 1);

    // Missing edge: locked drops when cnt saturates at 511
    @(posedge clk); #1;
    sample_clock = 1'b0;
    din          = 1'b0;
    n = 0;
    while (locked === 1'b1 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_cycles", 32'(n), 511);
    check("locked_after_timeout", 32'(locked), 0);
    check("err_on_timeout", 32'(err), 1);
    check("pcm_hold_timeout", 32'(pcm), 4096);

    // Restart: first rise re-arms, second gives a sample
    drive_period(256, M_ONE, M_ONE);
    @(posedge clk); #1;
    check("locked_rearm", 32'(locked), 1);
    push(16383, 0); drive_period(256, M_ONE, M_ONE);
    check("err_count_timeout", 32'(err_cnt), 2);

    // Mid-window reset, 100 cycles in
    repeat (100) begin
      @(negedge clk);
      sample_clock = 1'b0;
      din          = 1'b1;
    end
    check("pcm_before_reset", 32'(pcm), 16383);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_pcm", 32'(pcm), 0);
    check("midreset_locked", 32'(locked), 0);
    repeat (3) @(negedge clk);
    din   = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    drive_period(10, M_ZERO, M_ZERO);
    @(posedge clk); #1;
    check("locked_after_rearm_reset", 32'(locked), 1);
    push(0, 0);     drive_period(256, M_ZERO, M_ZERO);
    push(0, 0);     drive_period(256, M_ZERO, M_DAC);

    // Loopback from a sigma-delta DAC at pcm 8192
    push(8192, 64); drive_period(256, M_DAC, M_DAC);
    push(8192, 64); drive_period(256, M_DAC, M_DAC);
    push(8192, 64); drive_period(256, M_DAC, M_ZERO);

    repeat (5) @(negedge clk);
    check("all_samples_seen", 32'(exp_q.size()), 0);
    check("err_count_final", 32'(err_cnt), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_capture.md
# pdm_capture

Receive-side counterpart of the audio PWM/sigma-delta DAC. It takes a 1-bit pulse-density stream, either looped back from the DAC output pin or from an external 1-bit source. Over each sample period defined by `sample_clock`, it counts the ones in the stream and emits one unsigned PCM word per period, in the same format the DAC consumes. It sits beside the DAC in the audio subsystem and serves as the loopback and measurement path for the synth chain.

## Interface
Parameters:
- `BITDEPTH`, 14: width of the PCM output word; must be ≥ `SAMPLECLOCK_DIV`.
- `SAMPLECLOCK_DIV`, 8: log2 of the window length; N = 2**`SAMPLECLOCK_DIV` clk cycles per sample.

Ports:
- `clk`  in  1  system clock, 8 MHz in the synth build.
- `rst_n`  in  1  reset, asynchronous assert, active-low; deassertion is synchronised internally to `clk`.
- `sample_clock`  in  1  sample-rate clock, generated in the `clk` domain; only its rising edge is used.
- `din`  in  1  pulse-density input, asynchronous; passes through a 2-flop synchroniser.
- `pcm`  out  BITDEPTH  unsigned PCM sample of the last valid window.
- `pcm_valid`  out  1  one-cycle strobe when `pcm` updates.
- `locked`  out  1  high while in state RUN.
- `err`  out  1  one-cycle strobe on a window-length error.

## Operation
- Synchroniser:
  - `din` passes through 2 flops to give `din_s`.
  - Both flops reset to 0.
- Edge detect:
  - `sc_d` holds the previous-cycle value of `sample_clock`.
  - `rise` = `sample_clock & ~sc_d`.
  - `sc_d` resets to 1, so a `sample_clock` that is already high at reset does not produce a `rise`.
- Accumulator `acc`:
  - Width `SAMPLECLOCK_DIV`+1; counts 0..N.
  - On a non-`rise` cycle: `acc <= acc + din_s`.
  - On a `rise` cycle: `total = acc + din_s` (combinational), then `acc <= 0`.
  - The window is therefore the N `din_s` bits from the cycle after the previous `rise` up to and including the current `rise` cycle.
- Period counter `cnt`:
  - Width `SAMPLECLOCK_DIV`+1.
  - Cleared to 0 on `rise`; increments otherwise.
  - Saturates at 2N−1.
- Scaling:
  - `total` == N → `pcm` = 2**`BITDEPTH`−1 (all ones; saturate).
  - Otherwise → `pcm` = `total` << (`BITDEPTH`−`SAMPLECLOCK_DIV`).
  - No rounding and no filtering.
- State machine (2 states):
  - IDLE (reset state):
    - `rise` → RUN; `acc` and `cnt` cleared; no `pcm_valid`.
    - The partial window before the first edge is discarded.
  - RUN, on `rise` with `cnt` == N−1: `pcm` loaded; `pcm_valid` pulses.
  - RUN, on `rise` with `cnt` != N−1 (short or long period):
    - `err` pulses; no `pcm_valid`; `pcm` holds.
    - A new window starts and the block stays in RUN.
  - RUN, `cnt` reaches 2N−1 without a `rise` (missing edge):
    - `err` pulses; go to IDLE; `pcm` holds.
- Simultaneous events: a `rise` on the same cycle `cnt` would saturate counts as a short/long-period error only; `err` pulses once, not twice.
- Reset mid-window:
  - All state clears immediately.
  - The next `rise` after release re-arms the block, as from power-up.

## Timing
- Reset values:
  - Outputs: `pcm`=0, `pcm_valid`=0, `locked`=0, `err`=0.
  - Internal: state=IDLE, `acc`=0, `cnt`=0.
- Input latency: a `din` change reaches `din_s` 2 cycles later.
- Output timing:
  - `pcm` and `pcm_valid` are registered, valid in the cycle after the `rise` cycle.
  - `pcm_valid` is high for exactly 1 cycle per valid window.
- `err` is registered and high for 1 cycle, in the cycle after the detecting event.
- `locked`:
  - Goes high the cycle after the arming `rise`.
  - Goes low the cycle after a timeout to IDLE.
- Throughput: one sample per N cycles (31.25 kHz with default parameters).
- The first `pcm_valid` after reset comes on the second `rise` following release.

## Test plan
- Reset check: `rst_n` low with random `din` and `sample_clock` → all outputs 0. Release, then 3 `sample_clock` periods of N=256 with `din`=0 → `pcm_valid` pulses on the 2nd and 3rd edges, `pcm`=0, `locked`=1 from the cycle after the 1st edge.
- Full scale: `din`=1 held → `pcm`=16383 (saturated, `total`=256) on every window after the first; `err` never asserts.
- Half scale: `din` toggling every cycle → `total`=128, `pcm`=8192 each window. Also 64 ones per window → `pcm`=4096.
- Period error: one `sample_clock` period shortened to 200 cycles → `err` 1-cycle pulse, no `pcm_valid` for that window, `pcm` holds its prior value. The next 256-cycle window gives a normal `pcm_valid`.
- Missing edge: stop `sample_clock` after lock → `err` pulse and `locked`=0 once `cnt` reaches 511. Restart → the first `rise` re-arms with no valid; the second `rise` gives `pcm_valid`.
- Mid-window reset and loopback:
  - Assert `rst_n` 100 cycles into a window → immediate clear; the rearm sequence matches the reset check.
  - Drive `din` from the DAC with constant `pcm` 8192 → the captured value is within ±1 LSB×64 of 8192 after lock.
